// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: instruction kinds, opcode/funct constants and field packers shared with the control decoder.
// Rev 1.0
`default_nettype none

package mips_isa_pkg;

  typedef enum logic [4:0] {
    K_ADD  = 5'd0,  K_ADDU = 5'd1,  K_SUB  = 5'd2,  K_SUBU = 5'd3,
    K_AND  = 5'd4,  K_OR   = 5'd5,  K_XOR  = 5'd6,  K_NOR  = 5'd7,
    K_SLT  = 5'd8,  K_SLTU = 5'd9,  K_SLL  = 5'd10, K_SRL  = 5'd11,
    K_SRA  = 5'd12, K_SLLV = 5'd13, K_SRLV = 5'd14, K_JR   = 5'd15,
    K_JALR = 5'd16, K_ADDI = 5'd17, K_SLTI = 5'd18, K_ANDI = 5'd19,
    K_ORI  = 5'd20, K_LUI  = 5'd21, K_LW   = 5'd22, K_SW   = 5'd23,
    K_BEQ  = 5'd24, K_BNE  = 5'd25, K_J    = 5'd26, K_JAL  = 5'd27
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_word_pack.sv
// mips_word_pack: combinational descriptor -> 32-bit MIPS word, flags unsupported kinds.
// Rev 1.0
`default_nettype none

module mips_word_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        valid_kind
);

  always_comb begin
    word       = '0;
    valid_kind = 1'b1;
    case (kind_e'(kind))
      K_ADD:  word = rtype(rs, rt, rd, 5'd0, FN_ADD);
      K_ADDU: word = rtype(rs, rt, rd, 5'd0, FN_ADDU);
      K_SUB:  word = rtype(rs, rt, rd, 5'd0, FN_SUB);
      K_SUBU: word = rtype(rs, rt, rd, 5'd0, FN_SUBU);
      K_AND:  word = rtype(rs, rt, rd, 5'd0, FN_AND);
      K_OR:   word = rtype(rs, rt, rd, 5'd0, FN_OR);
      K_XOR:  word = rtype(rs, rt, rd, 5'd0, FN_XOR);
      K_NOR:  word = rtype(rs, rt, rd, 5'd0, FN_NOR);
      K_SLT:  word = rtype(rs, rt, rd, 5'd0, FN_SLT);
      K_SLTU: word = rtype(rs, rt, rd, 5'd0, FN_SLTU);
      K_SLLV: word = rtype(rs, rt, rd, 5'd0, FN_SLLV);
      K_SRLV: word = rtype(rs, rt, rd, 5'd0, FN_SRLV);
      // Immediate shifts take their operand from rt only
      K_SLL:  word = rtype(5'd0, rt, rd, shamt, FN_SLL);
      K_SRL:  word = rtype(5'd0, rt, rd, shamt, FN_SRL);
      K_SRA:  word = rtype(5'd0, rt, rd, shamt, FN_SRA);
      K_JR:   word = rtype(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      K_JALR: word = rtype(rs, 5'd0, rd, 5'd0, FN_JALR);
      K_ADDI: word = itype(OP_ADDI, rs, rt, imm);
      K_SLTI: word = itype(OP_SLTI, rs, rt, imm);
      K_ANDI: word = itype(OP_ANDI, rs, rt, imm);
      K_ORI:  word = itype(OP_ORI, rs, rt, imm);
      K_LUI:  word = itype(OP_LUI, 5'd0, rt, imm);
      K_LW:   word = itype(OP_LW, rs, rt, imm);
      K_SW:   word = itype(OP_SW, rs, rt, imm);
      K_BEQ:  word = itype(OP_BEQ, rs, rt, imm);
      K_BNE:  word = itype(OP_BNE, rs, rt, imm);
      K_J:    word = jtype(OP_J, target);
      K_JAL:  word = jtype(OP_JAL, target);
      default: valid_kind = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder: encodes a descriptor stream and writes words sequentially into IM.
// Rev 1.0
`default_nettype none

module mips_inst_encoder
  import mips_isa_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  output logic          im_we,
  input  logic          im_ready,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e      state, state_nxt;
  logic [AW:0] alloc;          // words given an address: count plus the pending one
  logic        last_accepted;
  logic        pend_last;
  logic [31:0] word;
  logic        valid_kind;
  logic        accept, wr_done, enter_run;

  mips_word_pack u_pack (
    .kind       (in_kind),
    .rs         (in_rs),
    .rt         (in_rt),
    .rd         (in_rd),
    .shamt      (in_shamt),
    .imm        (in_imm),
    .target     (in_target),
    .word       (word),
    .valid_kind (valid_kind)
  );

  assign wr_done   = im_we & im_ready;
  assign in_ready  = (state == S_RUN) & ~last_accepted & (alloc < DEPTH_C) & (~im_we | im_ready);
  assign accept    = in_valid & in_ready;
  assign enter_run = start & (state != S_RUN);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (wr_done & (pend_last | ((count + 1'b1) == DEPTH_C)))
          state_nxt = S_DONE;
        else if (accept & ~valid_kind & in_last)
          state_nxt = S_DONE;
      end
      S_DONE: if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_we         <= 1'b0;
      im_addr       <= '0;
      im_wdata      <= '0;
      err           <= 1'b0;
      err_addr      <= '0;
      count         <= '0;
      alloc         <= '0;
      last_accepted <= 1'b0;
      pend_last     <= 1'b0;
    end else if (enter_run) begin
      im_we         <= 1'b0;
      err           <= 1'b0;
      err_addr      <= '0;
      count         <= '0;
      alloc         <= '0;
      last_accepted <= 1'b0;
      pend_last     <= 1'b0;
    end else begin
      if (wr_done) begin
        count <= count + 1'b1;
        im_we <= 1'b0;
      end
      // A new word may reload the output register in the same cycle it drains
      if (accept) begin
        if (in_last) last_accepted <= 1'b1;
        if (valid_kind) begin
          im_we     <= 1'b1;
          im_addr   <= alloc[AW-1:0];
          im_wdata  <= word;
          pend_last <= in_last;
          alloc     <= alloc + 1'b1;
        end else if (!err) begin
          err      <= 1'b1;
          err_addr <= alloc[AW-1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_inst_encoder.sv
// tb_mips_inst_encoder: directed and random programs checked against a table-driven encoding model.
`timescale 1ns/1ps

module tb_mips_inst_encoder;

  localparam int AW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last, im_ready;
  logic [4:0]    in_kind, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_ready, im_we, busy, done, err;
  logic [AW-1:0] im_addr, err_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  mips_inst_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .count(count)
  );

  typedef struct {
    int          kind;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tg;
    bit          last;
  } desc_t;

  desc_t prog[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input int k, input int rs, input int rt, input int rd, input int sh,
                     input int imm, input int tg, input bit last);
    desc_t d;
    d.kind = k; d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd); d.sh = 5'(sh);
    d.imm = 16'(imm); d.tg = 26'(tg); d.last = last;
    prog.push_back(d);
  endtask

  // Encoding model from the instruction table: field positions by arithmetic weight
  function automatic logic [31:0] ref_enc(input desc_t d);
    int unsigned fn [0:16]  = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                                'h2A, 'h2B, 'h00, 'h02, 'h03, 'h04, 'h06, 'h08, 'h09};
    int unsigned op [17:27] = '{'h08, 'h0A, 'h0C, 'h0D, 'h0F, 'h23, 'h2B, 'h04, 'h05, 'h02, 'h03};
    int unsigned rs = d.rs, rt = d.rt, rd = d.rd, sh = d.sh;
    if (d.kind <= 16) begin
      if (d.kind >= 10 && d.kind <= 12) rs = 0;
      else if (d.kind == 15) begin rt = 0; rd = 0; sh = 0; end
      else if (d.kind == 16) begin rt = 0; sh = 0; end
      else sh = 0;
      return 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * (1 << 6) + fn[d.kind]);
    end else if (d.kind <= 25) begin
      if (d.kind == 21) rs = 0;
      return 32'(op[d.kind] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + d.imm);
    end
    return 32'(op[d.kind] * (1 << 26) + d.tg);
  endfunction

  // mode 0..100: im_ready percentage; mode -1: im_ready low on cycles 1..3
  task automatic run_prog(input string name, input int mode);
    logic [31:0]   ew[$];
    int            acc_cyc[$];
    int            n_acc = 0, nv = 0, e_err = 0, e_ea = 0, di = 0, wi = 0, cyc = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_a = '0;
    logic [31:0]   prev_d = '0;
    foreach (prog[i]) begin
      n_acc++;
      if (prog[i].kind < 28) begin ew.push_back(ref_enc(prog[i])); nv++; end
      else if (e_err == 0) begin e_err = 1; e_ea = nv; end
      if (prog[i].last || nv == DEPTH) break;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 200) begin
      in_valid = (di < prog.size());
      if (di < prog.size()) begin
        in_kind = 5'(prog[di].kind); in_rs = prog[di].rs; in_rt = prog[di].rt;
        in_rd = prog[di].rd; in_shamt = prog[di].sh; in_imm = prog[di].imm;
        in_target = prog[di].tg; in_last = prog[di].last;
      end else begin
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_imm = '0; in_target = '0; in_last = 1'b0;
      end
      im_ready = (mode < 0) ? !(cyc >= 1 && cyc <= 3) : ($urandom_range(99) < mode);
      #1;
      if (prev_stall) begin
        chk({name, " held_we"}, im_we, 1);
        chk({name, " held_addr"}, im_addr, prev_a);
        chk({name, " held_data"}, im_wdata, prev_d);
      end
      if (im_we && !im_ready) chk({name, " stall_in_ready"}, in_ready, 0);
      prev_stall = im_we && !im_ready;
      prev_a = im_addr;
      prev_d = im_wdata;
      if (im_we && im_ready) begin
        if (wi < ew.size()) begin
          chk($sformatf("%s addr[%0d]", name, wi), im_addr, wi);
          chk($sformatf("%s data[%0d]", name, wi), im_wdata, ew[wi]);
          if (mode == 100 && wi < acc_cyc.size())
            chk($sformatf("%s latency[%0d]", name, wi), cyc, acc_cyc[wi] + 1);
        end else begin
          chk({name, " extra_write"}, 1, 0);
        end
        wi++;
      end
      if (in_valid && in_ready) begin
        if (prog[di].kind < 28) acc_cyc.push_back(cyc);
        di++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    im_ready = 1'b0;
    #1;
    chk({name, " done"}, done, 1);
    chk({name, " busy"}, busy, 0);
    chk({name, " n_writes"}, wi, ew.size());
    chk({name, " n_accepted"}, di, n_acc);
    chk({name, " count"}, count, ew.size());
    chk({name, " err"}, err, e_err);
    if (e_err != 0) chk({name, " err_addr"}, err_addr, e_ea);
    chk({name, " in_ready_end"}, in_ready, 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; im_ready = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst im_we", im_we, 0);
    chk("rst im_addr", im_addr, 0);
    chk("rst im_wdata", im_wdata, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst busy_done", {busy, done}, 0);
    chk("rst err", {err, err_addr}, 0);
    chk("rst count", count, 0);
    @(negedge clk);

    prog.delete(); add(17, 0, 8, 0, 0, 5, 0, 1);
    run_prog("addi", 100);

    prog.delete(); add(0, 8, 9, 10, 7, 0, 0, 0); add(10, 9, 3, 2, 4, 0, 0, 1);
    run_prog("add_sll", 100);

    prog.delete(); add(21, 3, 1, 0, 0, 'h1234, 0, 0); add(26, 0, 0, 0, 0, 0, 'h0100000, 1);
    run_prog("lui_j", 100);

    prog.delete(); add(1, 1, 2, 3, 9, 0, 0, 0); add(13, 4, 5, 6, 1, 0, 0, 0); add(23, 7, 8, 0, 0, 'hBEEF, 0, 1);
    run_prog("stall", -1);

    prog.delete();
    add(20, 1, 2, 0, 0, 'h00FF, 0, 0); add(15, 31, 4, 5, 6, 0, 0, 0);
    add(30, 1, 1, 1, 1, 1, 1, 0); add(16, 2, 7, 31, 3, 0, 0, 1);
    run_prog("bad_kind", 100);

    prog.delete();
    for (int i = 0; i < 6; i++) add(i, i + 1, i + 2, i + 3, i, 0, 0, 0);
    run_prog("full", 100);

    for (int p = 0; p < 25; p++) begin
      int n;
      prog.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        add(($urandom_range(7) == 0) ? $urandom_range(28, 31) : $urandom_range(27),
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, i == n - 1);
      run_prog($sformatf("rnd%0d", p), $urandom_range(30, 100));
    end

    prog.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_kind = 5'd17; in_rt = 5'd4; in_imm = 16'h7777; in_last = 1'b0;
    im_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst pending_we", im_we, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst im_we", im_we, 0);
    chk("midrst im_addr", im_addr, 0);
    chk("midrst im_wdata", im_wdata, 0);
    chk("midrst in_ready", in_ready, 0);
    chk("midrst busy_done", {busy, done}, 0);
    chk("midrst err", {err, err_addr}, 0);
    chk("midrst count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
